// File: rtl/otbn_urnd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : otbn_urnd_pkg
// Description : Shared widths and FSM state encoding for the URND controller.
// Revision    : 1.0 - initial release
// ============================================================================
package otbn_urnd_pkg;

    localparam int UrndSeedW = 256;
    localparam int UrndDataW = 64;

    typedef enum logic [1:0] {
        UNSEEDED = 2'd0,
        FETCH    = 2'd1,
        READY    = 2'd2
    } urnd_state_e;

endpackage
`default_nettype wire

// File: rtl/otbn_urnd_arb.sv
`default_nettype none
// ============================================================================
// Module      : otbn_urnd_arb
// Description : Round-robin arbiter; pointer moves one past each granted index.
// Revision    : 1.0 - initial release
// ============================================================================
module otbn_urnd_arb #(
    parameter int NumReq = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NumReq-1:0] req_i,
    input  logic              en_i,
    output logic [NumReq-1:0] gnt_o
);

    localparam int PtrW = $clog2(NumReq);

    logic [PtrW-1:0] ptr_q;
    logic [PtrW-1:0] ptr_d;
    logic [PtrW-1:0] idx;
    logic [PtrW-1:0] gidx;
    logic            found;

    always_comb begin
        gnt_o = '0;
        gidx  = '0;
        idx   = '0;
        found = 1'b0;
        ptr_d = ptr_q;
        // Scan from the pointer upward with wrap; first requester wins.
        for (int k = 0; k < NumReq; k++) begin
            idx = PtrW'((int'(ptr_q) + k) % NumReq);
            if (!found && req_i[idx]) begin
                found = 1'b1;
                gidx  = idx;
            end
        end
        if (en_i && found) begin
            gnt_o[gidx] = 1'b1;
            ptr_d       = (gidx == PtrW'(NumReq - 1)) ? '0 : gidx + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/otbn_urnd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : otbn_urnd_ctrl
// Description : Seeds an external xoshiro PRNG from EDN and arbitrates random
//               words among requesters. OTBN_URND_RESEED_TIMER_EN enables an
//               automatic reseed every ReseedInterval grants.
// Revision    : 1.0 - initial release
// ============================================================================
module otbn_urnd_ctrl
    import otbn_urnd_pkg::*;
#(
    parameter int NumReq         = 2,
    parameter int ReseedInterval = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NumReq-1:0]    req_i,
    output logic [NumReq-1:0]    gnt_o,
    output logic [UrndDataW-1:0] data_o,
    input  logic                 reseed_req_i,
    output logic                 seeded_o,
    output logic                 lockup_err_o,
    output logic                 edn_req_o,
    input  logic                 edn_ack_i,
    input  logic [UrndSeedW-1:0] edn_data_i,
    output logic                 prng_seed_en_o,
    output logic [UrndSeedW-1:0] prng_seed_o,
    output logic                 prng_en_o,
    input  logic [UrndDataW-1:0] prng_data_i,
    input  logic                 prng_all_zero_i
);

    urnd_state_e state_q;
    urnd_state_e state_d;
    logic        grant_en;

`ifdef OTBN_URND_RESEED_TIMER_EN
    localparam int CntW = $clog2(ReseedInterval + 1);
    logic [CntW-1:0] cnt_q;
    logic [CntW-1:0] cnt_d;
`endif

    assign data_o      = prng_data_i;
    assign prng_seed_o = edn_data_i;
    assign prng_en_o   = grant_en;

    always_comb begin
        state_d        = state_q;
        grant_en       = 1'b0;
        edn_req_o      = 1'b0;
        prng_seed_en_o = 1'b0;
        lockup_err_o   = 1'b0;
        seeded_o       = 1'b0;
`ifdef OTBN_URND_RESEED_TIMER_EN
        cnt_d          = cnt_q;
`endif
        // Outputs are held quiet while reset is asserted, whatever the state.
        if (!rst_i) begin
            case (state_q)
                UNSEEDED: begin
                    if (reseed_req_i) state_d = FETCH;
                end
                FETCH: begin
                    edn_req_o = 1'b1;
                    if (edn_ack_i) begin
                        prng_seed_en_o = 1'b1;
                        state_d        = READY;
`ifdef OTBN_URND_RESEED_TIMER_EN
                        cnt_d          = '0;
`endif
                    end
                end
                READY: begin
                    seeded_o = 1'b1;
                    if (prng_all_zero_i) begin
                        lockup_err_o = 1'b1;
                        state_d      = FETCH;
                    end else if (reseed_req_i) begin
                        state_d = FETCH;
                    end else if (|req_i) begin
                        grant_en = 1'b1;
`ifdef OTBN_URND_RESEED_TIMER_EN
                        cnt_d = cnt_q + CntW'(1);
                        if (cnt_q == CntW'(ReseedInterval - 1)) state_d = FETCH;
`endif
                    end
                end
                default: state_d = UNSEEDED;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= UNSEEDED;
`ifdef OTBN_URND_RESEED_TIMER_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
`ifdef OTBN_URND_RESEED_TIMER_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    otbn_urnd_arb #(
        .NumReq (NumReq)
    ) u_arb (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .req_i  (req_i),
        .en_i   (grant_en),
        .gnt_o  (gnt_o)
    );

endmodule
`default_nettype wire
